mainmem_backdoor_engine: RTL
============================

Name: mainmem_backdoor_engine

Overview:
- Parametrised, multi-channel access engine for scratchpad (main) memory, used by the co-simulation system layer.
- Replaces ad-hoc force/release backdoor accesses.
- N requesters (cores, printf service, loader) share one memory port through round-robin arbitration.
- Supports single-beat write, multi-beat read, and multi-beat fetch-and-clear (the printf buffer drain) with per-beat responses.

Parameters:
- NUM_CH, 4, number of requester channels
- ADDR_W, 32, byte-address width
- DATA_W, 64, memory word width (multiple of 8)
- MAX_BEATS, 16, maximum beats per read/fetch-clear burst
- BEAT_W, $clog2(MAX_BEATS+1), width of the beat-count field

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_CH  per-channel request valid; held until accepted
- req_ready  out  NUM_CH  one-hot, one-cycle accept pulse
- req_op  in  2*NUM_CH  per channel: 0 READ, 1 WRITE, 2 FETCH_CLEAR, 3 reserved
- req_addr  in  ADDR_W*NUM_CH  per-channel base byte address
- req_wdata  in  DATA_W*NUM_CH  per-channel write data
- req_beats  in  BEAT_W*NUM_CH  per-channel burst length
- rsp_valid  out  NUM_CH  one-hot response-beat strobe to the owning channel
- rsp_data  out  DATA_W  response data (shared)
- rsp_last  out  1  final beat of the transaction
- rsp_err  out  1  error response (reserved op)
- mem_req  out  1  memory access strobe
- mem_we  out  1  write enable (qualified by mem_req)
- mem_addr  out  ADDR_W  word-aligned byte address
- mem_wdata  out  DATA_W  write data
- mem_mask  out  DATA_W/8  byte mask; all ones on every write
- mem_rdata  in  DATA_W  read data, valid one cycle after a read mem_req
- busy  out  1  engine not in IDLE

Behaviour:
- Reset (sync, active-high): state IDLE; all outputs 0; RR pointer set so ch0 has highest priority.
  - An in-flight transaction is abandoned with no response and no further memory access.
- FSM states: IDLE, RD, RD_WAIT, CLR, WR, ERR.
- IDLE (cycle T):
  - If any req_valid, grant the first asserted channel after the last granted one (wrapping).
  - Pulse req_ready[g] at T; latch op, addr, wdata, beats.
  - req_beats=0 is treated as 1; values above MAX_BEATS are clamped to MAX_BEATS.
  - Next state: READ/FETCH_CLEAR -> RD; WRITE -> WR; op 3 -> ERR.
- Address:
  - Low $clog2(DATA_W/8) bits forced to 0.
  - Beat i uses base + i*(DATA_W/8), wrapping modulo 2^ADDR_W.
- WR (T+1): mem_req=1, mem_we=1, mask all ones, wdata latched.
  - At T+2: rsp_valid[g]=1, rsp_data=0, rsp_last=1, rsp_err=0.
  - Return to IDLE at T+2; a new accept is possible at T+2.
  - Writes are always single-beat; beats is ignored.
- READ:
  - RD: mem_req=1, mem_we=0.
  - RD_WAIT: capture mem_rdata.
  - Next cycle: rsp_valid/rsp_data presented, registered.
  - Beat i response at T+3+2i; rsp_last on the final beat.
  - The next RD overlaps the response cycle.
- FETCH_CLEAR: per beat RD -> RD_WAIT -> CLR.
  - CLR writes 0 to the same address, and the captured data is presented on rsp in the CLR cycle.
  - Beat i response at T+3+3i.
  - The clear is always performed, including on the last beat.
- ERR (T+1): no memory access; at T+2 rsp_valid[g]=1, rsp_err=1, rsp_last=1, rsp_data=0.
- Responses have no backpressure; the requester must consume each beat.
- rsp_valid is 0 in all other cycles; rsp_data holds its last value.
- req_valid from other channels is ignored while busy and is arbitrated on the next IDLE cycle.
- The RR pointer updates only on accept.
- Simultaneous requests: grant by RR order only; op type has no influence.
- Address or op changes on a non-granted channel while pending are permitted; values are sampled at accept.

Decomposition:
- Package mainmem_bd_pkg:
  - op enum (BD_READ, BD_WRITE, BD_FETCH_CLEAR, BD_RSVD)
  - FSM state enum
  - BYTE_OFF_W = $clog2(DATA_W/8)
- Sub-module mainmem_bd_rr_arb:
  - Parametrised NUM_CH round-robin arbiter.
  - Inputs: request vector, accept.
  - Outputs: one-hot grant and grant index.
  - Holds the pointer; reset to ch0 priority.

Test Plan:
- ch1 WRITE addr 0x8000_0010 data 0xDEAD_BEEF_0123_4567 -> one mem write at 0x8000_0010, mask 0xFF; rsp_valid=4'b0010, last=1, two cycles after accept.
- ch0 READ addr 0x8000_0000 beats 4 (memory preloaded 0x11..0x44) -> four beats at T+3/5/7/9, addresses +8 each; rsp_last only on the 4th beat.
- ch2 FETCH_CLEAR beats 15 over a printf buffer -> 15 data beats each 3 cycles apart; a subsequent READ of the same 15 words returns all 0.
- All four channels assert simultaneously, each doing a WRITE -> grants in order 0,1,2,3; then re-request ch0 and ch3 -> next grant ch0, then ch3.
- req_op=3 on ch3 -> no mem_req, rsp_err=1, rsp_last=1; req_beats=0 and req_beats=31 -> 1 and 16 beats respectively; unaligned addr 0x...0D -> mem_addr 0x...08.
- rst asserted in the second beat of an 8-beat READ -> next cycle all outputs 0, state IDLE, no further beats; next request granted to ch0 first.

Source files
------------

// File: rtl/mainmem_bd_pkg.sv
// rtl/mainmem_bd_pkg.sv - shared types and helpers for the main-memory backdoor engine
//
// Contents:
//   bd_op_e        request opcode carried on req_op
//   bd_state_e     engine FSM state encoding
//   bd_byte_off_w  number of byte-offset address bits for a given word width
//   BYTE_OFF_W     byte-offset width for the default 64-bit word

package mainmem_bd_pkg;

   typedef enum logic [1:0] {
      BD_READ        = 2'd0,
      BD_WRITE       = 2'd1,
      BD_FETCH_CLEAR = 2'd2,
      BD_RSVD        = 2'd3
   } bd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD      = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_CLR     = 3'd3,
      ST_WR      = 3'd4,
      ST_ERR     = 3'd5
   } bd_state_e;

   function automatic int bd_byte_off_w(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   localparam int BYTE_OFF_W = bd_byte_off_w(64);

endpackage

// File: rtl/mainmem_bd_rr_arb.sv
// rtl/mainmem_bd_rr_arb.sv - round-robin arbiter for the backdoor engine requesters
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   req        per-channel request vector
//   accept     the current grant is taken this cycle; advances the pointer
//   gnt        one-hot grant (zero when nothing requests)
//   gnt_idx    binary index of the granted channel
//
// The pointer remembers the last accepted channel; the search starts just
// after it and wraps. Reset points it at the last channel so ch0 wins first.

module mainmem_bd_rr_arb #(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              accept,
   output logic [NUM_CH-1:0] gnt,
   output logic [IDX_W-1:0]  gnt_idx
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic             found;
   int               cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = (int'(ptr_q) + k) % NUM_CH;
         if (!found && req[cand[IDX_W-1:0]]) begin
            found                 = 1'b1;
            gnt[cand[IDX_W-1:0]]  = 1'b1;
            gnt_idx               = cand[IDX_W-1:0];
         end
      end
      ptr_d = (accept && found) ? gnt_idx : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= IDX_W'(NUM_CH - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/mainmem_backdoor_engine.sv
// rtl/mainmem_backdoor_engine.sv - multi-channel backdoor access engine for scratchpad memory
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            per-channel request handshake (ready is a one-cycle accept pulse)
//   req_op/addr/wdata/beats        per-channel request fields, packed channel-major
//   rsp_valid/data/last/err        registered response beats, one-hot to the owning channel
//   mem_req/we/addr/wdata/mask     single memory port; mem_rdata returns one cycle after a read
//   busy                           engine is not idle
//
// Beat flow: READ runs RD -> RD_WAIT per beat, FETCH_CLEAR runs RD -> RD_WAIT -> CLR.
// The beat captured in RD_WAIT is registered, so it appears on rsp in the cycle
// after RD_WAIT (the next RD for READ, the CLR for FETCH_CLEAR).

module mainmem_backdoor_engine
   import mainmem_bd_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int MAX_BEATS = 16,
   parameter int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        req_valid,
   output logic [NUM_CH-1:0]        req_ready,
   input  logic [2*NUM_CH-1:0]      req_op,
   input  logic [ADDR_W*NUM_CH-1:0] req_addr,
   input  logic [DATA_W*NUM_CH-1:0] req_wdata,
   input  logic [BEAT_W*NUM_CH-1:0] req_beats,
   output logic [NUM_CH-1:0]        rsp_valid,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     rsp_last,
   output logic                     rsp_err,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic [DATA_W/8-1:0]      mem_mask,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     busy
);

   localparam int                IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int                MASK_W     = DATA_W / 8;
   localparam int                OFF_W      = bd_byte_off_w(DATA_W);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;
   localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(MASK_W);

   bd_state_e           state_q, state_d;
   bd_op_e              op_q, op_d;
   logic [NUM_CH-1:0]   ch_oh_q, ch_oh_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [BEAT_W-1:0]   beats_q, beats_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [NUM_CH-1:0]   rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_last_q, rsp_last_d;
   logic                rsp_err_q, rsp_err_d;

   logic [NUM_CH-1:0]   gnt;
   logic [IDX_W-1:0]    gnt_idx;
   logic                accept;
   bd_op_e              op_in;
   logic [BEAT_W-1:0]   beats_in;
   logic                last_beat;

   mainmem_bd_rr_arb #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .accept  (accept),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Accept only from IDLE; requests arriving while busy wait for the next IDLE cycle.
   assign accept    = (state_q == ST_IDLE) && (|req_valid) && !rst;
   assign req_ready = accept ? gnt : '0;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      ch_oh_d     = ch_oh_q;
      cur_addr_d  = cur_addr_q;
      wdata_d     = wdata_q;
      beats_d     = beats_q;
      beat_cnt_d  = beat_cnt_q;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      rsp_last_d  = 1'b0;
      rsp_err_d   = 1'b0;
      op_in       = bd_op_e'(req_op[gnt_idx*2 +: 2]);
      beats_in    = req_beats[gnt_idx*BEAT_W +: BEAT_W];
      last_beat   = (beat_cnt_q == beats_q - BEAT_W'(1));

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d       = op_in;
               ch_oh_d    = gnt;
               cur_addr_d = req_addr[gnt_idx*ADDR_W +: ADDR_W] & ALIGN_MASK;
               wdata_d    = req_wdata[gnt_idx*DATA_W +: DATA_W];
               beat_cnt_d = '0;
               // Zero-length bursts mean one beat; oversize bursts saturate.
               if (beats_in == '0) begin
                  beats_d = BEAT_W'(1);
               end else if (beats_in > BEAT_W'(MAX_BEATS)) begin
                  beats_d = BEAT_W'(MAX_BEATS);
               end else begin
                  beats_d = beats_in;
               end
               case (op_in)
                  BD_READ, BD_FETCH_CLEAR: state_d = ST_RD;
                  BD_WRITE:                state_d = ST_WR;
                  default:                 state_d = ST_ERR;
               endcase
            end
         end

         ST_RD: begin
            state_d = ST_RD_WAIT;
         end

         ST_RD_WAIT: begin
            rsp_valid_d = ch_oh_q;
            rsp_data_d  = mem_rdata;
            rsp_last_d  = last_beat;
            if (op_q == BD_FETCH_CLEAR) begin
               state_d = ST_CLR;
            end else if (last_beat) begin
               state_d = ST_IDLE;
            end else begin
               // Next beat's RD overlaps the cycle presenting this beat.
               state_d    = ST_RD;
               beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               cur_addr_d = cur_addr_q + BEAT_BYTES;
            end
         end

         ST_CLR: begin
            if (last_beat) begin
               state_d = ST_IDLE;
            end else begin
               state_d    = ST_RD;
               beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               cur_addr_d = cur_addr_q + BEAT_BYTES;
            end
         end

         ST_WR: begin
            rsp_valid_d = ch_oh_q;
            rsp_data_d  = '0;
            rsp_last_d  = 1'b1;
            state_d     = ST_IDLE;
         end

         ST_ERR: begin
            rsp_valid_d = ch_oh_q;
            rsp_data_d  = '0;
            rsp_last_d  = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= BD_READ;
         ch_oh_q     <= '0;
         cur_addr_q  <= '0;
         wdata_q     <= '0;
         beats_q     <= '0;
         beat_cnt_q  <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_last_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         ch_oh_q     <= ch_oh_d;
         cur_addr_q  <= cur_addr_d;
         wdata_q     <= wdata_d;
         beats_q     <= beats_d;
         beat_cnt_q  <= beat_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_last_q  <= rsp_last_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_last  = rsp_last_q;
   assign rsp_err   = rsp_err_q;

   assign mem_req   = (state_q == ST_RD) || (state_q == ST_CLR) || (state_q == ST_WR);
   assign mem_we    = (state_q == ST_CLR) || (state_q == ST_WR);
   assign mem_addr  = cur_addr_q;
   // CLR writes zero; only WR carries the latched data.
   assign mem_wdata = (state_q == ST_WR) ? wdata_q : '0;
   assign mem_mask  = mem_we ? {MASK_W{1'b1}} : {MASK_W{1'b0}};
   assign busy      = (state_q != ST_IDLE);

endmodule
